// File: rtl/rails_pkg.sv
// Shared types and defaults for the rails stack-permutation checker.
package rails_pkg;

    localparam int unsigned MAX_N_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } state_t;

endpackage

// File: rtl/rails_top_enc.sv
// Priority encoder: index of the highest coach waiting in the station, 0 when empty.
module rails_top_enc #(
    parameter int unsigned MAX_N = 10,
    parameter int unsigned W     = 4
) (
    input  logic [MAX_N:1] pending,
    output logic [W-1:0]   top_c
);

    always_comb begin
        top_c = '0;
        for (int unsigned i = 1; i <= MAX_N; i++) begin
            if (pending[i]) top_c = W'(i);
        end
    end

endmodule

// File: rtl/rails_checker.sv
// Decides whether a single dead-end station can turn inbound order 1..N into
// the streamed target order, honouring an optional station capacity.
module rails_checker
    import rails_pkg::*;
#(
    parameter  int unsigned MAX_N = MAX_N_DEFAULT,
    localparam int unsigned DW    = $clog2(MAX_N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] data,
    input  logic [DW-1:0] cap,
    output logic          valid,
    output logic          result
);

    localparam int unsigned CW = DW + 1;

    state_t          state;
    logic [DW-1:0]   n_r;
    logic [CW-1:0]   n_left;
    logic [CW-1:0]   next_in;
    logic [MAX_N:1]  pending;
    logic [CW-1:0]   count;
    logic [DW-1:0]   cap_r;
    logic            ok;
    logic            ready_r;

    logic [DW-1:0]   top;
    logic [CW-1:0]   t_w;
    logic [CW-1:0]   occ;
    logic [MAX_N:1]  set_mask;
    logic            ok_n;
    logic [MAX_N:1]  pending_n;
    logic [CW-1:0]   count_n;
    logic [CW-1:0]   next_in_n;

    // No transfer can happen while reset is held.
    assign in_ready = ready_r & ~reset;
    assign t_w      = {1'b0, data};
    assign occ      = count + (t_w - next_in);

    rails_top_enc #(.MAX_N(MAX_N), .W(DW)) u_top_enc (
        .pending (pending),
        .top_c   (top)
    );

    // Coaches next_in..t-1 are pushed into the station when t arrives early.
    always_comb begin
        set_mask = '0;
        for (int unsigned i = 1; i <= MAX_N; i++) begin
            set_mask[i] = (CW'(i) >= next_in) && (CW'(i) < t_w);
        end
    end

    // Per-entry update; the station is only tracked while the frame is still feasible.
    always_comb begin
        ok_n      = ok;
        pending_n = pending;
        count_n   = count;
        next_in_n = next_in;
        if (t_w == '0 || t_w > {1'b0, n_r}) begin
            ok_n = 1'b0;
        end else if (t_w >= next_in) begin
            if (cap_r != '0 && occ > {1'b0, cap_r}) begin
                ok_n = 1'b0;
            end else if (ok) begin
                pending_n = pending | set_mask;
                count_n   = occ;
                next_in_n = t_w + CW'(1);
            end
        end else if (t_w == {1'b0, top}) begin
            if (ok) begin
                for (int unsigned i = 1; i <= MAX_N; i++) begin
                    if (CW'(i) == t_w) pending_n[i] = 1'b0;
                end
                count_n = count - CW'(1);
            end
        end else begin
            ok_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            n_r     <= '0;
            n_left  <= '0;
            next_in <= '0;
            pending <= '0;
            count   <= '0;
            cap_r   <= '0;
            ok      <= 1'b0;
            ready_r <= 1'b1;
            valid   <= 1'b0;
            result  <= 1'b0;
        end else begin
            valid  <= 1'b0;
            result <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        n_r     <= data;
                        n_left  <= t_w;
                        next_in <= CW'(1);
                        pending <= '0;
                        count   <= '0;
                        cap_r   <= cap;
                        ok      <= (t_w <= CW'(MAX_N));
                        if (data == '0) begin
                            state   <= DONE;
                            valid   <= 1'b1;
                            result  <= 1'b1;
                            ready_r <= 1'b0;
                        end else begin
                            state <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (in_valid) begin
                        ok      <= ok_n;
                        pending <= pending_n;
                        count   <= count_n;
                        next_in <= next_in_n;
                        n_left  <= n_left - CW'(1);
                        if (n_left == CW'(1)) begin
                            state   <= DONE;
                            valid   <= 1'b1;
                            result  <= ok_n;
                            ready_r <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rails_checker.sv
// Directed bench for rails_checker: frame table plus reset / gap / DONE corner sequences.
module tb_rails_checker;

    localparam int unsigned DW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] data;
    logic [DW-1:0] cap;
    logic          valid;
    logic          result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          n;
        int          cap;
        logic [63:0] ents;   // entry j is nibble (n-1-j), i.e. written left to right
        logic        exp;
        int          gaps;
    } vec_t;

    vec_t vecs[$];

    rails_checker #(.MAX_N(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data     (data),
        .cap      (cap),
        .valid    (valid),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input int n, input int c, input logic [63:0] e, input logic x, input int g);
        vec_t v;
        v.n = n; v.cap = c; v.ents = e; v.exp = x; v.gaps = g;
        vecs.push_back(v);
    endtask

    task automatic gap_cycles(input int g);
        if (g != 0) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                in_valid = 1'b0;
                data     = DW'($urandom);
                check("gap_valid", valid, 1'b0);
            end
        end
    endtask

    // One accepted word; returns #1 after the edge that takes it.
    task automatic xfer(input logic [DW-1:0] w);
        @(negedge clk);
        check("in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        data     = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        logic [63:0] sh;
        gap_cycles(v.gaps);
        cap = DW'(v.cap);
        xfer(DW'(v.n));
        if (v.n > 0) check({tag, "_hdr_novalid"}, valid, 1'b0);
        for (int j = 0; j < v.n; j++) begin
            sh = v.ents >> (4 * (v.n - 1 - j));
            gap_cycles(v.gaps);
            xfer(sh[DW-1:0]);
            if (j != v.n - 1) check({tag, "_mid_novalid"}, valid, 1'b0);
        end
        check({tag, "_valid"}, valid, 1'b1);
        check({tag, "_result"}, result, v.exp);
        check({tag, "_done_ready"}, in_ready, 1'b0);
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, valid, 1'b0);
        check({tag, "_result_drop"}, result, 1'b0);
        check({tag, "_ready_back"}, in_ready, 1'b1);
    endtask

    initial begin
        vec_t v;
        reset    = 1'b1;
        in_valid = 1'b0;
        data     = '0;
        cap      = '0;

        add(5,  0, 64'h12345,        1'b1, 0);
        add(5,  0, 64'h54123,        1'b0, 0);
        add(3,  1, 64'h321,          1'b0, 0);
        add(3,  2, 64'h321,          1'b1, 0);
        add(2,  0, 64'h22,           1'b0, 0);
        add(0,  0, 64'h0,            1'b1, 0);
        add(12, 0, 64'h123456789ABC, 1'b0, 0);
        add(1,  0, 64'h1,            1'b1, 0);
        add(10, 9, 64'hA987654321,   1'b1, 0);
        add(10, 8, 64'hA987654321,   1'b0, 0);
        add(3,  0, 64'h012,          1'b0, 0);
        add(3,  0, 64'h142,          1'b0, 0);
        add(3,  0, 64'h312,          1'b0, 0);
        add(4,  0, 64'h2143,         1'b1, 1);
        add(10, 0, 64'h1A98765432,   1'b1, 1);

        // Reset behaviour
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", in_ready, 1'b0);
        check("rst_valid", valid, 1'b0);
        check("rst_result", result, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", in_ready, 1'b1);

        foreach (vecs[i]) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Data offered during DONE must not be taken as a header
        cap = '0;
        xfer(DW'(1));
        xfer(DW'(1));
        check("done_valid", valid, 1'b1);
        check("done_ready", in_ready, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        data     = DW'(2);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("done_ignore_valid_drop", valid, 1'b0);
        v.n = 1; v.cap = 0; v.ents = 64'h1; v.exp = 1'b1; v.gaps = 0;
        run_frame(v, "after_done");

        // Reset mid-frame aborts it silently
        xfer(DW'(4));
        gap_cycles(1);
        xfer(DW'(1));
        gap_cycles(1);
        xfer(DW'(2));
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        data     = DW'(3);
        @(posedge clk);
        #1;
        check("midrst_valid", valid, 1'b0);
        @(negedge clk);
        check("midrst_ready_low", in_ready, 1'b0);
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("midrst_no_verdict", valid, 1'b0);
        end
        v.n = 2; v.cap = 0; v.ents = 64'h21; v.exp = 1'b1; v.gaps = 1;
        run_frame(v, "midrst_next");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so a wedged design still reaches a summary.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rails_checker.md
# rails_checker

Parametrised stack-permutation (rails) checker. It receives a coach count N, then a stream of N target coach numbers, and decides whether a single dead-end station can reorder the inbound sequence 1..N into that target order. It extends the fixed 10-coach checker in four ways:
- a parametrised maximum coach count;
- an input handshake that allows gaps;
- a runtime station-capacity limit;
- explicit rejection of malformed frames.

It sits as the checker core of the HW2 rails design.

## Interface
Parameters:
- MAX_N, default 10: largest legal coach count; must be at least 1.
- DW, default $clog2(MAX_N+1): width of data/cap (localparam; not overridden).

Ports:
- clk  in  1  single clock; all logic is on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  data (and cap on header) is presented this cycle.
- in_ready  out  1  checker accepts data this cycle; transfer = in_valid & in_ready.
- data  in  DW  header word = N, then target coach numbers 1..N.
- cap  in  DW  station capacity, sampled with the header; 0 = unlimited.
- valid  out  1  one-cycle pulse: the verdict is present.
- result  out  1  1 = sequence achievable under cap; qualified by valid.

## Operation
- States:
  - IDLE: wait for the header.
  - RECV: consume N entries.
  - DONE: present the verdict for one cycle, then go to IDLE.
- Registers:
  - `n_left` (DW+1 bits).
  - `next_in` (next inbound coach, DW+1 bits).
  - `pending[MAX_N:1]` bitmap of coaches currently in the station.
  - `count` (DW+1 bits, station occupancy).
  - `cap_r`.
  - `ok` flag.
- Header transfer in IDLE:
  - `n_left=N`, `next_in=1`, `pending=0`, `count=0`, `cap_r=cap`, `ok=(N<=MAX_N)`.
  - N=0 goes directly to DONE; otherwise go to RECV.
- Entry transfer in RECV, with t=data and top = highest set bit index of `pending` (0 if empty):
  - t==0, or t>N: `ok=0`.
  - t>=`next_in` (new coach): occupancy' = `count`+(t−`next_in`).
    - If cap_r≠0 and occupancy'>cap_r: `ok=0`.
    - Else set `pending[next_in..t-1]`, `count`=occupancy', `next_in`=t+1.
    - Coach t passes straight through and is not counted.
  - t<`next_in` and t==top: clear `pending[t]`, `count`−1.
  - t<`next_in` and t≠top: `ok=0`. This covers both a wrong order and a duplicate.
  - Once `ok=0`, the bitmap may be left unchanged; only `ok` matters thereafter.
  - `n_left`−1 on every entry; when it reaches 0, go to DONE.
- Frames with N>MAX_N are consumed entry-by-entry to keep the stream aligned; `pending` updates are masked to MAX_N bits and the verdict is 0.
- Arithmetic: all comparisons are unsigned at DW+1 bits; no wrap-around is possible since `next_in`≤MAX_N+1.

## Timing
- Reset (synchronous) → state IDLE, valid=0, result=0, in_ready=0 during the reset cycle, then 1 in the first cycle after reset.
- Reset asserted mid-frame aborts the frame: no verdict is emitted, and the next transfer is treated as a header.
- in_ready=1 in IDLE and RECV, 0 in DONE. data presented in DONE is not accepted.
- Outputs are registered. If the last entry (or an N=0 header) transfers at cycle k:
  - valid=1 with result=`ok` at cycle k+1.
  - valid=0 at k+2, and the next header can be accepted at k+2.
  - result returns to 0 when valid falls.
- Gaps (in_valid=0) in RECV hold all state. There is no timeout.
- Minimum frame period: N+2 cycles.

## Structure
- Shared package `rails_pkg`:
  - state enum {IDLE, RECV, DONE};
  - MAX_N default constant.
- Sub-module `rails_top_enc`: parametrised priority encoder, `pending[MAX_N:1]` → top index (0 when empty), purely combinational.
- The range-set mask for `pending[next_in..t-1]` is generated inline in the checker.

## Test plan
- N=5, entries 1 2 3 4 5, cap=0 → valid pulse one cycle after the 5th entry, result=1.
- N=5, entries 5 4 1 2 3, cap=0 → result=0 (1 is not top after popping 4).
- N=3, entries 3 2 1:
  - cap=1 → result=0 (occupancy 2>1);
  - same frame with cap=2 → result=1.
- N=2, entries 2 2 → result=0 (duplicate); N=0 header → valid next cycle, result=1.
- MAX_N=10: N=12 frame with 12 entries → consumed fully, result=0, and the following N=1/[1] frame → result=1.
- Frame N=4 with random in_valid gaps, and a reset asserted after 2 entries → no valid pulse; the next frame N=2, 2 1 → result=1; in_ready=0 in each DONE cycle.
